// File: rtl/interrupt_cycle_ctrl.sv
// Interrupt-cycle sequencer: IEN/R flip-flops, request detect and RT0..RT2 strobes.
// Optional IRQ_MASK_EN adds irq_mask[1:0] to gate FGI/FGO at the R-set decision.
module interrupt_cycle_ctrl #(
    parameter int                SEL_W  = 3,
    parameter logic [SEL_W-1:0]  PC_SEL = SEL_W'(2),
    parameter logic [SEL_W-1:0]  TR_SEL = SEL_W'(6),
    parameter int                CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_ic,
    input  logic             fetch_t0,
    input  logic             sc_t012,
    input  logic             fgi,
    input  logic             fgo,
    input  logic             ion,
    input  logic             iof,
`ifdef IRQ_MASK_EN
    input  logic [1:0]       irq_mask,
`endif
    output logic             ien,
    output logic             r_flag,
    output logic             irq_active,
    output logic             clr_ar,
    output logic             load_tr,
    output logic [SEL_W-1:0] bus_sel,
    output logic             mem_write,
    output logic             clr_pc,
    output logic             inc_pc,
    output logic             clr_sc,
    output logic [CNT_W-1:0] irq_count
);

    typedef enum logic [1:0] {IDLE, RT0, RT1, RT2} state_t;
    state_t state;
    logic   req;

`ifdef IRQ_MASK_EN
    assign req = (fgi & irq_mask[0]) | (fgo & irq_mask[1]);
`else
    assign req = fgi | fgo;
`endif

    always_ff @(posedge clk) begin
        if (!reset_ic) begin
            state     <= IDLE;
            ien       <= 1'b0;
            r_flag    <= 1'b0;
            irq_count <= '0;
        end else begin
            // RT2 clear beats iof, which beats ion
            if (state == RT2)  ien <= 1'b0;
            else if (iof)      ien <= 1'b0;
            else if (ion)      ien <= 1'b1;

            if (state == RT2)
                r_flag <= 1'b0;
            else if (state == IDLE && ien && req && !sc_t012)
                r_flag <= 1'b1;

            case (state)
                IDLE: if (r_flag && fetch_t0) state <= RT0;
                RT0:  state <= RT1;
                RT1:  state <= RT2;
                RT2: begin
                    state <= IDLE;
                    if (irq_count != {CNT_W{1'b1}}) irq_count <= irq_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode the current state so they line up with it in the same cycle
    assign irq_active = (state != IDLE);
    assign clr_ar     = (state == RT0);
    assign load_tr    = (state == RT0);
    assign mem_write  = (state == RT1);
    assign clr_pc     = (state == RT1);
    assign inc_pc     = (state == RT2);
    assign clr_sc     = (state == RT2);

    always_comb begin
        bus_sel = '0;
        case (state)
            RT0:     bus_sel = PC_SEL;
            RT1:     bus_sel = TR_SEL;
            default: bus_sel = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_cycle_ctrl.sv
// Directed table plus hand sequences for interrupt_cycle_ctrl.
module tb_interrupt_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_ic, fetch_t0, sc_t012, fgi, fgo, ion, iof;
    logic       ien, r_flag, irq_active, clr_ar, load_tr, mem_write, clr_pc, inc_pc, clr_sc;
    logic [2:0] bus_sel;
    logic [7:0] irq_count;
`ifdef IRQ_MASK_EN
    logic [1:0] irq_mask = 2'b11;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_cycle_ctrl dut (
        .clk(clk), .reset_ic(reset_ic), .fetch_t0(fetch_t0), .sc_t012(sc_t012),
        .fgi(fgi), .fgo(fgo), .ion(ion), .iof(iof),
`ifdef IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .ien(ien), .r_flag(r_flag), .irq_active(irq_active), .clr_ar(clr_ar),
        .load_tr(load_tr), .bus_sel(bus_sel), .mem_write(mem_write), .clr_pc(clr_pc),
        .inc_pc(inc_pc), .clr_sc(clr_sc), .irq_count(irq_count)
    );

    typedef struct packed {
        logic       rst, ft0, sc, fi, fo, on, of;
        logic       e_ien, e_r, e_act;
        logic [2:0] e_bus;
        logic [5:0] e_strb;  // {clr_ar, load_tr, mem_write, clr_pc, inc_pc, clr_sc}
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " ien"}, int'(ien), int'(v.e_ien));
        chk({tag, " r_flag"}, int'(r_flag), int'(v.e_r));
        chk({tag, " irq_active"}, int'(irq_active), int'(v.e_act));
        chk({tag, " bus_sel"}, int'(bus_sel), int'(v.e_bus));
        chk({tag, " strobes"}, int'({clr_ar, load_tr, mem_write, clr_pc, inc_pc, clr_sc}),
            int'(v.e_strb));
        chk({tag, " irq_count"}, int'(irq_count), int'(v.e_cnt));
    endtask

    // One complete interrupt cycle from IDLE with ien=0 and r_flag=0
    task automatic run_cycle();
        ion = 1; fgi = 1; step();
        ion = 0; step();
        fetch_t0 = 1; step();
        fetch_t0 = 0; step(); step(); step();
        fgi = 0;
    endtask

    initial begin
        reset_ic = 0; fetch_t0 = 0; sc_t012 = 0; fgi = 1; fgo = 0; ion = 1; iof = 0;
        step(); step();
        chk("reset ien", int'(ien), 0);
        chk("reset r_flag", int'(r_flag), 0);
        chk("reset bus_sel", int'(bus_sel), 0);

        // Reset during RT1 abandons the cycle
        reset_ic = 1; ion = 1; fgi = 1; step();
        ion = 0; step();
        chk("mid r set", int'(r_flag), 1);
        fetch_t0 = 1; step();
        chk("mid rt0 load_tr", int'(load_tr), 1);
        fetch_t0 = 0; step();
        chk("mid rt1 mem_write", int'(mem_write), 1);
        reset_ic = 0; step();
        chk("mid rst mem_write", int'(mem_write), 0);
        chk("mid rst active", int'(irq_active), 0);
        chk("mid rst r_flag", int'(r_flag), 0);
        chk("mid rst count", int'(irq_count), 0);
        reset_ic = 1; fgi = 0; step();
        chk("mid after inc_pc", int'(inc_pc), 0);

        //           rst ft0 sc fi fo on of  ien r act bus  strb       cnt
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,3'd0,6'b000000,8'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,6'b000000,8'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'd2,6'b110000,8'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'd6,6'b001100,8'd0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,3'd0,6'b000011,8'd0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd1};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd1};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,3'd0,6'b000000,8'd1};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd1};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'd0,6'b000000,8'd1};

        for (int i = 0; i < 12; i++) begin
            reset_ic = vecs[i].rst; fetch_t0 = vecs[i].ft0; sc_t012 = vecs[i].sc;
            fgi = vecs[i].fi; fgo = vecs[i].fo; ion = vecs[i].on; iof = vecs[i].of;
            step();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end
        reset_ic = 1; fetch_t0 = 0; fgi = 0; ion = 0; iof = 0;

        // ien=0 with fgo pending never sets R
        fgo = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("noien r_flag c%0d", i), int'(r_flag), 0);
        end

        // sc_t012 blocks R until it falls
        ion = 1; sc_t012 = 1; step();
        ion = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sc blk r_flag c%0d", i), int'(r_flag), 0);
        end
        sc_t012 = 0; step();
        chk("sc release r_flag", int'(r_flag), 1);

        // iof during RT1: ien clears, cycle still finishes
        fetch_t0 = 1; step();
        chk("iof rt0 load_tr", int'(load_tr), 1);
        fetch_t0 = 0; step();
        chk("iof rt1 mem_write", int'(mem_write), 1);
        iof = 1; step();
        iof = 0;
        chk("iof rt2 inc_pc", int'(inc_pc), 1);
        chk("iof rt2 ien", int'(ien), 0);
        fgo = 0; step();
        chk("iof done count", int'(irq_count), 2);
        chk("iof done active", int'(irq_active), 0);

        // Saturation at 255
        for (int i = 0; i < 253; i++) run_cycle();
        chk("sat reach", int'(irq_count), 255);
        run_cycle();
        chk("sat hold", int'(irq_count), 255);
        chk("sat r_flag", int'(r_flag), 0);

`ifdef IRQ_MASK_EN
        irq_mask = 2'b01; ion = 1; fgo = 1; step();
        ion = 0; step(); step();
        chk("mask fgo r_flag", int'(r_flag), 0);
        fgi = 1; step();
        chk("mask fgi r_flag", int'(r_flag), 1);
        fgi = 0; fgo = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
